// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizing for the RAM streaming sequencer.
package ram_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   localparam int DEF_ADDR_W     = 8;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_RD_LAT     = 1;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/ram_stream_if.sv
// Command, write-stream and read-stream handshakes of the RAM sequencer.
interface ram_stream_if
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_read;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output cmd_valid, cmd_read, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_read, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/byte_fifo.sv
// Small synchronous first-word-fall-through FIFO; push and pop may coincide, even when full.
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clock_50mhz,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [PW:0]   CNT_ONE = 1;
   localparam logic [PW:0]   CNT_MAX = DEPTH;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock_50mhz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ram_stream_ctrl.sv
// Burst sequencer owning a single-port RAM: streams writes in, streams reads out through a FIFO.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   WRITE | one RAM write per write-stream handshake
//   READ  | issuing read addresses while the FIFO has room for the result
//   DRAIN | all addresses issued, waiting for RAM data and FIFO to empty
module ram_stream_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LAT     = DEF_RD_LAT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clock_50mhz,
   input  logic              reset,
   ram_stream_if.slave       bus,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);
   localparam int CW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] A_ONE   = 1;
   localparam logic [CW+1:0]     OCC_MAX = FIFO_DEPTH;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] remaining;
   logic [RD_LAT:0]   rd_pipe;
   logic [CW:0]       fifo_count;
   logic [CW:0]       inflight;
   logic [CW+1:0]     occupancy;
   logic              fifo_empty;
   logic              fifo_full;
   logic              wr_fire;
   logic              rd_issue;
   logic              rd_pop;

   // One bit per outstanding read; it falls out of the top on the capture edge.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= RD_LAT; i++) inflight = inflight + {{CW{1'b0}}, rd_pipe[i]};
   end

   assign occupancy     = {1'b0, fifo_count} + {1'b0, inflight};
   assign bus.cmd_ready = (state == IDLE);
   assign bus.wr_ready  = (state == WRITE);
   assign bus.rd_valid  = !fifo_empty;
   assign wr_fire       = bus.wr_ready && bus.wr_valid;
   assign rd_issue      = (state == READ) && !fifo_full && (occupancy < OCC_MAX);
   assign rd_pop        = bus.rd_valid && bus.rd_ready;
   assign busy          = (state != IDLE) || ram_wren;

   always_ff @(posedge clock_50mhz or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         addr        <= '0;
         remaining   <= '0;
         rd_pipe     <= '0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_wren    <= 1'b0;
      end else begin
         ram_wren <= 1'b0;
         rd_pipe  <= {rd_pipe[RD_LAT-1:0], rd_issue};
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  addr      <= bus.cmd_addr;
                  remaining <= bus.cmd_len;
                  state     <= bus.cmd_read ? READ : WRITE;
               end
            end
            WRITE: begin
               if (wr_fire) begin
                  ram_address <= addr;
                  ram_data    <= bus.wr_data;
                  ram_wren    <= 1'b1;
                  addr        <= addr + A_ONE;
                  if (remaining == '0) state <= IDLE;
                  else remaining <= remaining - A_ONE;
               end
            end
            READ: begin
               if (rd_issue) begin
                  ram_address <= addr;
                  addr        <= addr + A_ONE;
                  if (remaining == '0) state <= DRAIN;
                  else remaining <= remaining - A_ONE;
               end
            end
            DRAIN: begin
               if (inflight == '0 && fifo_empty) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
      .clock_50mhz (clock_50mhz),
      .reset       (reset),
      .push        (rd_pipe[RD_LAT]),
      .din         (ram_q),
      .pop         (rd_pop),
      .dout        (bus.rd_data),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count)
   );
endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Bench for ram_stream_ctrl: behavioural RAM, golden memory shadow and per-cycle handshake model.
module tb_ram_stream_ctrl;
   logic       clock_50mhz = 1'b0;
   logic       reset = 1'b1;
   logic       busy;
   logic       ram_wren;
   logic [7:0] ram_address;
   logic [7:0] ram_data;
   logic [7:0] ram_q = 8'h00;

   always #10 clock_50mhz = ~clock_50mhz;

   ram_stream_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   ram_stream_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
      .clock_50mhz (clock_50mhz),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q)
   );

   // ram1: registered address in, q one edge later.
   logic [7:0] ram_mem [256];
   always @(posedge clock_50mhz) begin
      if (ram_wren) ram_mem[ram_address] <= ram_data;
      ram_q <= ram_mem[ram_address];
   end

   int cyc = 0;
   always @(posedge clock_50mhz) cyc++;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state: what the spec says the block is doing, not how.
   logic [7:0] gold [256];
   logic [7:0] exp_rd_q [$];
   bit         m_idle = 1'b1;
   bit         m_is_rd = 1'b0;
   bit         m_fin = 1'b0;
   int         m_left = 0;
   logic [7:0] m_addr = 8'h00;
   bit         exp_wren = 1'b0;
   logic [7:0] exp_addr = 8'h00;
   logic [7:0] exp_data = 8'h00;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] wlog_a [$];
   logic [7:0] wlog_d [$];

   always @(negedge clock_50mhz) begin
      if (reset) begin
         m_idle     = 1'b1;
         m_is_rd    = 1'b0;
         m_fin      = 1'b0;
         exp_wren   = 1'b0;
         prev_stall = 1'b0;
         exp_rd_q.delete();
      end else begin
         chk("cmd_ready", bus.cmd_ready, m_idle);
         chk("wr_ready", bus.wr_ready, !m_idle && !m_is_rd);
         chk("busy", busy, !m_idle || exp_wren);
         chk("ram_wren", ram_wren, exp_wren);
         if (exp_wren) begin
            chk("ram_address", ram_address, exp_addr);
            chk("ram_data", ram_data, exp_data);
         end
         if (ram_wren) begin
            wlog_a.push_back(ram_address);
            wlog_d.push_back(ram_data);
         end
         if (prev_stall) begin
            chk("rd_valid_hold", bus.rd_valid, 1);
            chk("rd_data_hold", bus.rd_data, prev_data);
         end
         if (bus.rd_valid && bus.rd_ready) begin
            if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", bus.rd_data, exp_rd_q.pop_front());
         end
         chk("fifo_count_max", dut.u_fifo.count <= 4, 1);
         prev_stall = bus.rd_valid && !bus.rd_ready;
         prev_data  = bus.rd_data;

         // Predict the coming edge.
         exp_wren = 1'b0;
         if (m_idle) begin
            if (bus.cmd_valid) begin
               m_idle  = 1'b0;
               m_fin   = 1'b0;
               m_is_rd = bus.cmd_read;
               m_addr  = bus.cmd_addr;
               m_left  = int'(bus.cmd_len) + 1;
               if (m_is_rd)
                  for (int i = 0; i < m_left; i++) exp_rd_q.push_back(gold[8'(int'(bus.cmd_addr) + i)]);
            end
         end else if (!m_is_rd) begin
            if (bus.wr_valid) begin
               exp_wren     = 1'b1;
               exp_addr     = m_addr;
               exp_data     = bus.wr_data;
               gold[m_addr] = bus.wr_data;
               m_addr       = m_addr + 8'd1;
               m_left--;
               if (m_left == 0) m_idle = 1'b1;
            end
         end else begin
            if (m_fin) m_idle = 1'b1;
            else if (bus.rd_valid && bus.rd_ready) begin
               m_left--;
               if (m_left == 0) m_fin = 1'b1;
            end
         end
      end
   end

   logic [7:0] rlog [$];
   int         rcyc [$];

   task automatic send_cmd(input bit rd, input logic [7:0] a, input logic [7:0] l, output int acc);
      acc = -1;
      bus.cmd_read  = rd;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock_50mhz);
         if (bus.cmd_ready) begin
            @(posedge clock_50mhz); #1;
            acc = cyc;
            break;
         end
      end
      bus.cmd_valid = 1'b0;
      chk("cmd_accept", acc >= 0, 1);
   endtask

   task automatic write_stream(input logic [7:0] d [$], input int max_gap);
      int g;
      bit ok;
      foreach (d[i]) begin
         g = $urandom_range(0, max_gap);
         bus.wr_valid = 1'b0;
         repeat (g) begin @(posedge clock_50mhz); #1; end
         bus.wr_valid = 1'b1;
         bus.wr_data  = d[i];
         ok = 1'b0;
         for (int t = 0; t < 100; t++) begin
            @(negedge clock_50mhz);
            if (bus.wr_ready) begin ok = 1'b1; break; end
         end
         @(posedge clock_50mhz); #1;
         chk("wr_accept", ok, 1);
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic read_consume(input int n, input bit rnd, output int first_valid);
      int got;
      got = 0;
      first_valid = -1;
      rlog.delete();
      rcyc.delete();
      for (int t = 0; t < 5000 && got < n; t++) begin
         bus.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clock_50mhz);
         if (bus.rd_valid && first_valid < 0) first_valid = cyc;
         if (bus.rd_valid && bus.rd_ready) begin
            got++;
            rlog.push_back(bus.rd_data);
            rcyc.push_back(cyc);
         end
         @(posedge clock_50mhz); #1;
      end
      chk("rd_count", got, n);
      bus.rd_ready = 1'b1;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clock_50mhz);
         if (bus.cmd_ready) begin ok = 1'b1; break; end
      end
      @(posedge clock_50mhz); #1;
      chk("idle_timeout", ok, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "watchdog");
   end

   logic [7:0] t1_d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
   logic [7:0] t3_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] t3_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

   initial begin
      logic [7:0] q [$];
      int acc;
      int fv;
      int n_ok;
      bus.cmd_valid = 1'b0;
      bus.cmd_read  = 1'b0;
      bus.cmd_addr  = 8'h00;
      bus.cmd_len   = 8'h00;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = 8'h00;
      bus.rd_ready  = 1'b1;

      repeat (2) @(negedge clock_50mhz);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_ram_address", ram_address, 8'h00);
      chk("rst_ram_data", ram_data, 8'h00);
      chk("rst_ram_wren", ram_wren, 0);
      @(posedge clock_50mhz); #1;
      reset = 1'b0;
      repeat (2) begin @(posedge clock_50mhz); #1; end

      // Basic write, no stall
      wlog_a.delete(); wlog_d.delete();
      q.delete(); foreach (t1_d[i]) q.push_back(t1_d[i]);
      send_cmd(1'b0, 8'h10, 8'd3, acc);
      write_stream(q, 0);
      chk("t1_wr_cycles", cyc - acc, 4);
      @(negedge clock_50mhz);
      chk("t1_cmd_ready_after", bus.cmd_ready, 1);
      @(posedge clock_50mhz); #1;
      chk("t1_pulses", wlog_a.size(), 4);
      for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
         chk("t1_wr_addr", wlog_a[i], 8'h10 + 8'(i));
         chk("t1_wr_data", wlog_d[i], t1_d[i]);
      end

      // Read back with rd_ready high
      send_cmd(1'b1, 8'h10, 8'd3, acc);
      read_consume(4, 1'b0, fv);
      chk("t2_first_valid", fv - acc, 3);
      for (int i = 0; i < 4 && i < rlog.size(); i++) chk("t2_rd_data", rlog[i], t1_d[i]);
      if (rcyc.size() == 4) chk("t2_consecutive", rcyc[3] - rcyc[0], 3);
      wait_idle();

      // Address wrap
      wlog_a.delete(); wlog_d.delete();
      q.delete(); foreach (t3_d[i]) q.push_back(t3_d[i]);
      send_cmd(1'b0, 8'hFE, 8'd3, acc);
      write_stream(q, 1);
      send_cmd(1'b1, 8'hFE, 8'd3, acc);
      read_consume(4, 1'b0, fv);
      wait_idle();
      for (int i = 0; i < 4 && i < wlog_a.size(); i++) chk("t3_wr_addr", wlog_a[i], t3_a[i]);
      for (int i = 0; i < 4 && i < rlog.size(); i++) chk("t3_rd_data", rlog[i], t3_d[i]);

      // Write stream with gaps
      wlog_a.delete(); wlog_d.delete();
      q.delete(); for (int i = 0; i < 8; i++) q.push_back(8'($urandom_range(0, 255)));
      send_cmd(1'b0, 8'h80, 8'd7, acc);
      write_stream(q, 3);
      wait_idle();
      chk("t6_pulses", wlog_a.size(), 8);

      // Fill the whole RAM at full rate, then read it all under random backpressure
      q.delete(); for (int i = 0; i < 256; i++) q.push_back(8'($urandom_range(0, 255)));
      send_cmd(1'b0, 8'h00, 8'hFF, acc);
      write_stream(q, 0);
      chk("full_wr_cycles", cyc - acc, 256);
      send_cmd(1'b1, 8'h00, 8'hFF, acc);
      read_consume(256, 1'b1, fv);
      wait_idle();
      n_ok = 0;
      for (int i = 0; i < rlog.size(); i++) if (rlog[i] == q[i]) n_ok++;
      chk("full_rd_matches", n_ok, 256);

      // Reset in the middle of a read burst
      bus.rd_ready = 1'b0;
      send_cmd(1'b1, 8'h40, 8'h1F, acc);
      n_ok = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clock_50mhz);
         if (dut.u_fifo.count == 2) begin n_ok = 1; break; end
      end
      chk("rst_mid_fifo2", n_ok, 1);
      reset = 1'b1;
      @(posedge clock_50mhz); #1;
      chk("rst_mid_rd_valid", bus.rd_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
      chk("rst_mid_ram_wren", ram_wren, 0);
      repeat (2) begin @(posedge clock_50mhz); #1; end
      chk("rst_mid_ram_wren2", ram_wren, 0);
      reset = 1'b0;
      bus.rd_ready = 1'b1;
      @(posedge clock_50mhz); #1;
      send_cmd(1'b1, 8'h40, 8'd3, acc);
      read_consume(4, 1'b0, fv);
      wait_idle();
      chk("post_rst_first_valid", fv - acc, 3);
      for (int i = 0; i < 4 && i < rlog.size(); i++) chk("post_rst_rd", rlog[i], q[8'h40 + i]);

      repeat (3) @(posedge clock_50mhz);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
